// File: rtl/rf_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard_if
// Description : ID issue / WB retire / status bundle for the GR write
//               scoreboard. master = pipeline side, slave = scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_scoreboard_if #(
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            flush;
    logic            id_issue_valid;
    logic            id_issue_gr_we;
    logic [AW-1:0]   id_issue_dest;
    logic [AW-1:0]   id_rs1;
    logic            id_rs1_use;
    logic [AW-1:0]   id_rs2;
    logic            id_rs2_use;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic            id_stall;
    logic [NREG-1:0] busy_vec;
    logic            scb_err;

    modport master (
        output flush, id_issue_valid, id_issue_gr_we, id_issue_dest,
               id_rs1, id_rs1_use, id_rs2, id_rs2_use, rf_we, rf_waddr,
        input  id_stall, busy_vec, scb_err
    );

    modport slave (
        input  flush, id_issue_valid, id_issue_gr_we, id_issue_dest,
               id_rs1, id_rs1_use, id_rs2, id_rs2_use, rf_we, rf_waddr,
        output id_stall, busy_vec, scb_err
    );
endinterface
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-GR pending-write counters between ID issue and WB retire;
//               raises id_stall on RAW or counter saturation. Optional macro
//               RF_SCB_WB_BYPASS_EN lets a source clear its busy state in the
//               same cycle its last pending write retires.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    rf_scoreboard_if.slave    bus
);
    localparam int             AW      = $clog2(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [1:NREG-1];
    logic [CNT_W-1:0] cnt_d [1:NREG-1];
    logic             scb_err_q;
    logic             scb_err_d;

    logic [CNT_W-1:0] w_cnt [NREG];
    logic [NREG-1:0]  w_busy;
    logic             w_rs1_busy;
    logic             w_rs2_busy;
    logic             w_raw;
    logic             w_sat;
    logic             w_stall;
    logic             w_issue_fire;
    logic             w_retire_fire;
    logic             w_underflow;

    // r0 is presented as a constant zero counter so lookups need no special case
    always_comb begin
        w_cnt[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            w_cnt[r] = cnt_q[r];
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_busy[r] = (w_cnt[r] != '0);
        end
    end

`ifdef RF_SCB_WB_BYPASS_EN
    always_comb begin
        w_rs1_busy = w_busy[bus.id_rs1] &
                     !((w_cnt[bus.id_rs1] == CNT_ONE) && bus.rf_we && (bus.rf_waddr == bus.id_rs1));
        w_rs2_busy = w_busy[bus.id_rs2] &
                     !((w_cnt[bus.id_rs2] == CNT_ONE) && bus.rf_we && (bus.rf_waddr == bus.id_rs2));
    end
`else
    always_comb begin
        w_rs1_busy = w_busy[bus.id_rs1];
        w_rs2_busy = w_busy[bus.id_rs2];
    end
`endif

    always_comb begin
        w_raw = (bus.id_rs1_use & w_rs1_busy) | (bus.id_rs2_use & w_rs2_busy);
        // A retire to the same register frees the slot the issue needs
        w_sat = bus.id_issue_gr_we & (w_cnt[bus.id_issue_dest] == CNT_MAX) &
                !(bus.rf_we && (bus.rf_waddr == bus.id_issue_dest));
        w_stall       = bus.id_issue_valid & (w_raw | w_sat);
        w_issue_fire  = bus.id_issue_valid & bus.id_issue_gr_we & (bus.id_issue_dest != '0) &
                        !w_stall & !bus.flush;
        w_retire_fire = bus.rf_we & (bus.rf_waddr != '0) & (w_cnt[bus.rf_waddr] != '0) & !bus.flush;
        w_underflow   = bus.rf_we & (bus.rf_waddr != '0) & (w_cnt[bus.rf_waddr] == '0) & !bus.flush;
        scb_err_d     = scb_err_q | w_underflow;
    end

    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (bus.flush) begin
                cnt_d[r] = '0;
            end else if (w_issue_fire && (bus.id_issue_dest == AW'(r)) &&
                         !(w_retire_fire && (bus.rf_waddr == AW'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (w_retire_fire && (bus.rf_waddr == AW'(r)) &&
                         !(w_issue_fire && (bus.id_issue_dest == AW'(r)))) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            scb_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            scb_err_q <= scb_err_d;
        end
    end

    assign bus.id_stall = w_stall;
    assign bus.busy_vec = w_busy;
    assign bus.scb_err  = scb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_scoreboard
// Description : Directed scenarios with literal expectations, then randomized
//               traffic checked every cycle against a counter-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_scoreboard;
    localparam int NREG = 32;
    localparam int MAXC = 3;

    logic clk;
    logic reset;
    rf_scoreboard_if #(.NREG(NREG)) bus ();

    rf_scoreboard #(.NREG(NREG), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int mcnt [NREG];
    bit merr;
    bit model_ok;
    int n_checks;
    int n_fail;

`ifdef RF_SCB_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit src_busy(input int r);
        if (r == 0 || mcnt[r] == 0) return 1'b0;
        if (BYPASS && mcnt[r] == 1 && bus.rf_we && int'(bus.rf_waddr) == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_stall();
        bit raw, sat;
        raw = (bus.id_rs1_use && src_busy(int'(bus.id_rs1))) ||
              (bus.id_rs2_use && src_busy(int'(bus.id_rs2)));
        sat = bus.id_issue_gr_we && mcnt[bus.id_issue_dest] == MAXC &&
              !(bus.rf_we && bus.rf_waddr == bus.id_issue_dest);
        return bus.id_issue_valid && (raw || sat);
    endfunction

    task automatic compare_model();
        logic [31:0] ev;
        ev = '0;
        for (int r = 1; r < NREG; r++) ev[r] = (mcnt[r] > 0);
        check("busy_vec", bus.busy_vec, ev);
        check("id_stall", 32'(bus.id_stall), 32'(exp_stall()));
        check("scb_err", 32'(bus.scb_err), 32'(merr));
    endtask

    task automatic model_update(input bit rst, input bit fl, input bit st);
        int d, w;
        d = int'(bus.id_issue_dest);
        w = int'(bus.rf_waddr);
        if (rst) begin
            foreach (mcnt[r]) mcnt[r] = 0;
            merr = 0;
            model_ok = 1;
        end else if (!model_ok) begin
            // state unknown until the first reset edge
        end else if (fl) begin
            foreach (mcnt[r]) mcnt[r] = 0;
        end else begin
            bit iss, ret;
            iss = bus.id_issue_valid && bus.id_issue_gr_we && d != 0 && !st;
            ret = bus.rf_we && w != 0 && mcnt[w] > 0;
            if (bus.rf_we && w != 0 && mcnt[w] == 0) merr = 1;
            if (ret) mcnt[w] = mcnt[w] - 1;
            if (iss) mcnt[d] = mcnt[d] + 1;
        end
    endtask

    // Inputs are driven at the negedge; outputs compared, then the edge taken
    task automatic tick();
        bit st, rst, fl;
        #1;
        if (model_ok) compare_model();
        st  = exp_stall();
        rst = reset;
        fl  = bus.flush;
        @(posedge clk);
        model_update(rst, fl, st);
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input bit we, input int dest,
                          input int rs1, input bit u1, input int rs2, input bit u2);
        bus.id_issue_valid = v;
        bus.id_issue_gr_we = we;
        bus.id_issue_dest  = 5'(dest);
        bus.id_rs1         = 5'(rs1);
        bus.id_rs1_use     = u1;
        bus.id_rs2         = 5'(rs2);
        bus.id_rs2_use     = u2;
    endtask

    task automatic set_wb(input bit we, input int addr);
        bus.rf_we    = we;
        bus.rf_waddr = 5'(addr);
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0);
        bus.flush = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_ok = 0;
        merr     = 0;
        foreach (mcnt[r]) mcnt[r] = 0;
        reset = 1'b1;
        idle();
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;

        // reset state
        #1;
        check("rst_busy", bus.busy_vec, 32'h0);
        check("rst_stall", 32'(bus.id_stall), 32'h0);
        check("rst_err", 32'(bus.scb_err), 32'h0);
        tick();

        // RAW on r5, retire, stall release timing
        set_id(1, 1, 5, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 5, 1, 0, 0);
        #1;
        check("raw_stall", 32'(bus.id_stall), 32'h1);
        check("raw_busy", bus.busy_vec, 32'h20);
        tick();
        set_wb(1, 5);
        #1;
        check("raw_retire_stall", 32'(bus.id_stall), BYPASS ? 32'h0 : 32'h1);
        tick();
        set_wb(0, 0);
        #1;
        check("raw_after_stall", 32'(bus.id_stall), 32'h0);
        check("raw_after_busy", bus.busy_vec, 32'h0);
        tick();

        // saturation on r7
        set_id(1, 1, 7, 0, 0, 0, 0);
        tick(); tick(); tick();
        #1;
        check("sat_stall", 32'(bus.id_stall), 32'h1);
        check("sat_busy", bus.busy_vec, 32'h80);
        tick();
        set_wb(1, 7);
        #1;
        check("sat_retire_stall", 32'(bus.id_stall), 32'h0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        #1;
        check("sat_two_retired", bus.busy_vec, 32'h80);
        tick();
        set_wb(0, 0);
        #1;
        check("sat_drained", bus.busy_vec, 32'h0);
        tick();

        // simultaneous issue/retire same and different regs
        set_id(1, 1, 3, 0, 0, 0, 0); tick();
        set_wb(1, 3); tick();
        set_id(1, 1, 4, 0, 0, 0, 0); set_wb(0, 0); tick();
        set_id(1, 1, 3, 0, 0, 0, 0); set_wb(1, 4); tick();
        idle();
        #1;
        check("same_diff_busy", bus.busy_vec, 32'h8);
        tick();
        set_wb(1, 3); tick(); tick();
        set_wb(0, 0);
        #1;
        check("same_diff_drain", bus.busy_vec, 32'h0);
        check("same_diff_err", 32'(bus.scb_err), 32'h0);
        tick();

        // underflow error, r0 issue
        set_wb(1, 9); tick();
        set_wb(0, 0);
        #1;
        check("uflow_err", 32'(bus.scb_err), 32'h1);
        check("uflow_busy", bus.busy_vec, 32'h0);
        tick();
        set_id(1, 1, 0, 0, 0, 0, 0); tick();
        idle();
        #1;
        check("r0_busy", bus.busy_vec, 32'h0);
        tick();

        // flush with simultaneous issue
        set_id(1, 1, 2, 0, 0, 0, 0); tick(); tick();
        set_id(1, 1, 8, 0, 0, 0, 0); tick();
        set_id(1, 1, 10, 0, 0, 0, 0); bus.flush = 1'b1; tick();
        idle();
        set_id(1, 0, 0, 2, 1, 8, 1);
        #1;
        check("flush_busy", bus.busy_vec, 32'h0);
        check("flush_stall", 32'(bus.id_stall), 32'h0);
        check("flush_err_kept", 32'(bus.scb_err), 32'h1);
        tick();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int wa;
            reset     = ($urandom_range(0, 399) == 0);
            bus.flush = ($urandom_range(0, 59) == 0);
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 11), $urandom_range(0, 1) == 1);
            wa = $urandom_range(0, 11);
            for (int k = 0; k < 4 && mcnt[wa] == 0; k++) wa = $urandom_range(0, 11);
            set_wb($urandom_range(0, 2) != 0, wa);
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
